serial_word_loader: RTL and testbench

Parallel-to-serial loader that sits directly upstream of the `shift_register` stage. It accepts a WIDTH-bit word over a valid/ready handshake and drives the register's serial input and shift enable for exactly WIDTH enabled cycles, LSB first. After those cycles the downstream `o_DATA` equals the accepted word. It then pulses a completion flag. It is used to load scan/fault-injection patterns into SBTR cell chains.

---
 rtl/serial_word_loader_if.sv | 36 +++
 rtl/serial_word_loader.sv | 105 ++++++++++
 tb/tb_serial_word_loader.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_word_loader_if.sv
// Handshake and serial-drive bundle between an upstream word source and the loader.
// The loader connects through the slave modport; the word source uses master.
interface serial_word_loader_if #(
    parameter int WIDTH = 10
);
    logic             i_VALID;
    logic [WIDTH-1:0] i_DATA;
    logic             o_READY;
    logic             i_STALL;
    logic             o_SI;
    logic             o_EN;
    logic             o_BUSY;
    logic             o_DONE;

    modport master (
        output i_VALID,
        output i_DATA,
        output i_STALL,
        input  o_READY,
        input  o_SI,
        input  o_EN,
        input  o_BUSY,
        input  o_DONE
    );

    modport slave (
        input  i_VALID,
        input  i_DATA,
        input  i_STALL,
        output o_READY,
        output o_SI,
        output o_EN,
        output o_BUSY,
        output o_DONE
    );
endinterface

// File: rtl/serial_word_loader.sv
// Parallel-to-serial loader feeding a right-shifting shift register.
// A word accepted over valid/ready is sent LSB first over exactly WIDTH enabled
// cycles, so the downstream register ends up holding the word unchanged.
// A one-cycle completion flag follows the last bit.
module serial_word_loader #(
    parameter int WIDTH = 10
) (
    input  logic                i_CLK,
    input  logic                i_RST,
    serial_word_loader_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   data_buf;
    logic [CNT_W-1:0]   bit_cnt;
    logic               accept;
    logic               shift_fire;

    // A word is taken only while idle; a bit is consumed on every unstalled SHIFT cycle.
    assign accept     = (state == IDLE) && bus.i_VALID;
    assign shift_fire = (state == SHIFT) && !bus.i_STALL;

    // State register; reset aborts any load in flight without a completion pulse.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode: leave SHIFT only on the edge that consumes the final bit.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (shift_fire && (bit_cnt == LAST_BIT)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Word buffer and bit counter: load on accept, shift right with zero fill per sent bit.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            data_buf <= '0;
            bit_cnt  <= '0;
        end else if (accept) begin
            data_buf <= bus.i_DATA;
            bit_cnt  <= '0;
        end else if (shift_fire) begin
            data_buf <= data_buf >> 1;
            bit_cnt  <= bit_cnt + CNT_W'(1);
        end
    end

    // Output decode from state; the shift enable alone passes i_STALL through combinationally.
    always_comb begin
        bus.o_READY = 1'b0;
        bus.o_SI    = 1'b0;
        bus.o_EN    = 1'b0;
        bus.o_BUSY  = 1'b0;
        bus.o_DONE  = 1'b0;
        unique case (state)
            IDLE: begin
                bus.o_READY = 1'b1;
            end
            SHIFT: begin
                bus.o_BUSY = 1'b1;
                bus.o_SI   = data_buf[0];
                bus.o_EN   = !bus.i_STALL;
            end
            DONE: begin
                bus.o_BUSY = 1'b1;
                bus.o_DONE = 1'b1;
            end
            default: begin
                bus.o_READY = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_word_loader.sv
// Directed bench for serial_word_loader: a WIDTH=10 instance carries the main
// scenarios, WIDTH=2 and WIDTH=33 instances load random words.
// Each instance drives a behavioural model of the downstream shift register.
module tb_serial_word_loader;

    logic i_CLK;
    logic i_RST;

    int errorCount;
    int checkCount;
    int cycleNum;

    serial_word_loader_if #(.WIDTH(10)) bus10 ();
    serial_word_loader_if #(.WIDTH(2))  bus2  ();
    serial_word_loader_if #(.WIDTH(33)) bus33 ();

    serial_word_loader #(.WIDTH(10)) dut10 (.i_CLK(i_CLK), .i_RST(i_RST), .bus(bus10.slave));
    serial_word_loader #(.WIDTH(2))  dut2  (.i_CLK(i_CLK), .i_RST(i_RST), .bus(bus2.slave));
    serial_word_loader #(.WIDTH(33)) dut33 (.i_CLK(i_CLK), .i_RST(i_RST), .bus(bus33.slave));

    // Downstream register models and event logs
    logic [9:0]  ds10;
    logic [1:0]  ds2;
    logic [32:0] ds33;
    int          enCnt10;
    int          enCnt2;
    int          enCnt33;
    int          acceptLog10[$];
    logic [9:0]  doneLog10[$];
    logic [1:0]  doneLog2[$];
    logic [32:0] doneLog33[$];

    // Free-running clock
    initial begin
        i_CLK = 1'b0;
        forever #5 i_CLK = ~i_CLK;
    end

    // Downstream shift registers: shift right, serial input enters at the MSB
    always @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            ds10 <= '0;
            ds2  <= '0;
            ds33 <= '0;
        end else begin
            if (bus10.o_EN) ds10 <= {bus10.o_SI, ds10[9:1]};
            if (bus2.o_EN)  ds2  <= {bus2.o_SI, ds2[1]};
            if (bus33.o_EN) ds33 <= {bus33.o_SI, ds33[32:1]};
        end
    end

    // Cycle counter, enable-pulse counters, accept times and downstream value at each DONE
    always @(posedge i_CLK) begin
        cycleNum <= cycleNum + 1;
        if (bus10.o_EN) enCnt10 <= enCnt10 + 1;
        if (bus2.o_EN)  enCnt2  <= enCnt2 + 1;
        if (bus33.o_EN) enCnt33 <= enCnt33 + 1;
        if (bus10.i_VALID && bus10.o_READY) acceptLog10.push_back(cycleNum);
        if (bus10.o_DONE) doneLog10.push_back(ds10);
        if (bus2.o_DONE)  doneLog2.push_back(ds2);
        if (bus33.o_DONE) doneLog33.push_back(ds33);
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance from one falling edge to the next
    task automatic tick();
        @(posedge i_CLK);
        @(negedge i_CLK);
    endtask

    task automatic applyStimulus(input logic valid, input logic [9:0] data, input logic stall);
        bus10.i_VALID = valid;
        bus10.i_DATA  = data;
        bus10.i_STALL = stall;
        #1;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_ready"}, 64'(bus10.o_READY), 64'(1));
        checkOutput({tag, "_en"},    64'(bus10.o_EN),    64'(0));
        checkOutput({tag, "_si"},    64'(bus10.o_SI),    64'(0));
        checkOutput({tag, "_busy"},  64'(bus10.o_BUSY),  64'(0));
        checkOutput({tag, "_done"},  64'(bus10.o_DONE),  64'(0));
    endtask

    task automatic waitDone10(input int target, input string tag);
        for (int i = 0; i < 100 && doneLog10.size() < target; i++) tick();
        checkOutput({tag, "_done_seen"}, 64'(doneLog10.size()), 64'(target));
    endtask

    task automatic loadW2(input logic [1:0] word);
        int enBase;
        int doneBase;
        enBase   = enCnt2;
        doneBase = doneLog2.size();
        bus2.i_VALID = 1'b1;
        bus2.i_DATA  = word;
        tick();
        bus2.i_VALID = 1'b0;
        for (int i = 0; i < 20 && doneLog2.size() <= doneBase; i++) tick();
        checkOutput("w2_done_seen", 64'(doneLog2.size()), 64'(doneBase + 1));
        checkOutput("w2_en_pulses", 64'(enCnt2 - enBase), 64'(2));
        checkOutput("w2_value",     64'(doneLog2[doneBase]), 64'(word));
    endtask

    task automatic loadW33(input logic [32:0] word);
        int enBase;
        int doneBase;
        enBase   = enCnt33;
        doneBase = doneLog33.size();
        bus33.i_VALID = 1'b1;
        bus33.i_DATA  = word;
        tick();
        bus33.i_VALID = 1'b0;
        for (int i = 0; i < 80 && doneLog33.size() <= doneBase; i++) tick();
        checkOutput("w33_done_seen", 64'(doneLog33.size()), 64'(doneBase + 1));
        checkOutput("w33_en_pulses", 64'(enCnt33 - enBase), 64'(33));
        checkOutput("w33_value",     64'(doneLog33[doneBase]), 64'(word));
    endtask

    initial begin
        logic [9:0]  word;
        logic [1:0]  w2;
        logic [32:0] w33;
        int          enBase;
        int          doneBase;
        int          accBase;
        int          bitIdx;
        logic        stall;

        errorCount = 0;
        checkCount = 0;
        cycleNum   = 0;
        enCnt10    = 0;
        enCnt2     = 0;
        enCnt33    = 0;
        i_RST      = 1'b1;
        bus10.i_VALID = 1'b0; bus10.i_DATA = '0; bus10.i_STALL = 1'b0;
        bus2.i_VALID  = 1'b0; bus2.i_DATA  = '0; bus2.i_STALL  = 1'b0;
        bus33.i_VALID = 1'b0; bus33.i_DATA = '0; bus33.i_STALL = 1'b0;

        // Reset state
        @(negedge i_CLK);
        @(negedge i_CLK);
        checkIdleOutputs("reset");
        i_RST = 1'b0;
        tick();

        // Basic load of 10'h2B5: bits 1,0,1,0,1,1,0,1,0,1
        $display("[TB] basic load");
        word     = 10'h2B5;
        enBase   = enCnt10;
        doneBase = doneLog10.size();
        applyStimulus(1'b1, word, 1'b0);
        tick();
        applyStimulus(1'b0, 10'h000, 1'b0);
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("basic_en%0d", i), 64'(bus10.o_EN), 64'(1));
            checkOutput($sformatf("basic_si%0d", i), 64'(bus10.o_SI), 64'(word[i]));
            checkOutput("basic_ready_low", 64'(bus10.o_READY), 64'(0));
            tick();
        end
        checkOutput("basic_done",      64'(bus10.o_DONE), 64'(1));
        checkOutput("basic_done_en",   64'(bus10.o_EN),   64'(0));
        checkOutput("basic_done_busy", 64'(bus10.o_BUSY), 64'(1));
        tick();
        checkOutput("basic_ready_again", 64'(bus10.o_READY), 64'(1));
        checkOutput("basic_done_low",    64'(bus10.o_DONE),  64'(0));
        checkOutput("basic_ds",          64'(ds10),          64'(10'h2B5));
        checkOutput("basic_en_pulses",   64'(enCnt10 - enBase), 64'(10));
        checkOutput("basic_done_count",  64'(doneLog10.size() - doneBase), 64'(1));

        // Stall during the 3rd and 7th SHIFT cycles: DONE two cycles later
        $display("[TB] stall");
        enBase = enCnt10;
        applyStimulus(1'b1, word, 1'b0);
        tick();
        bitIdx = 0;
        for (int k = 0; k < 12; k++) begin
            stall = (k == 2) || (k == 6);
            applyStimulus(1'b0, 10'h000, stall);
            checkOutput($sformatf("stall_en%0d", k), 64'(bus10.o_EN), 64'(!stall));
            checkOutput($sformatf("stall_si%0d", k), 64'(bus10.o_SI), 64'(word[bitIdx]));
            checkOutput($sformatf("stall_done%0d", k), 64'(bus10.o_DONE), 64'(0));
            if (!stall) bitIdx++;
            tick();
        end
        applyStimulus(1'b0, 10'h000, 1'b0);
        checkOutput("stall_done",      64'(bus10.o_DONE), 64'(1));
        checkOutput("stall_en_pulses", 64'(enCnt10 - enBase), 64'(10));
        checkOutput("stall_ds",        64'(ds10), 64'(10'h2B5));
        tick();

        // Back-to-back with i_VALID held: second word accepted WIDTH+2 cycles later
        $display("[TB] back-to-back");
        accBase  = acceptLog10.size();
        doneBase = doneLog10.size();
        applyStimulus(1'b1, 10'h3FF, 1'b0);
        tick();
        applyStimulus(1'b1, 10'h001, 1'b0);
        for (int i = 0; i < 60 && acceptLog10.size() < accBase + 2; i++) tick();
        applyStimulus(1'b0, 10'h000, 1'b0);
        checkOutput("b2b_accepts", 64'(acceptLog10.size() - accBase), 64'(2));
        if (acceptLog10.size() >= accBase + 2)
            checkOutput("b2b_spacing", 64'(acceptLog10[accBase + 1] - acceptLog10[accBase]), 64'(12));
        waitDone10(doneBase + 2, "b2b");
        checkOutput("b2b_first",  64'(doneLog10[doneBase]),     64'(10'h3FF));
        checkOutput("b2b_second", 64'(doneLog10[doneBase + 1]), 64'(10'h001));
        tick();

        // Reset after four shifted bits, then a fresh load of 10'h155
        $display("[TB] reset mid-operation");
        doneBase = doneLog10.size();
        applyStimulus(1'b1, 10'h2B5, 1'b0);
        tick();
        applyStimulus(1'b0, 10'h000, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("midrst_busy_before", 64'(bus10.o_BUSY), 64'(1));
        i_RST = 1'b1;
        #1;
        checkIdleOutputs("midrst");
        tick();
        tick();
        i_RST = 1'b0;
        tick();
        checkOutput("midrst_no_done", 64'(doneLog10.size() - doneBase), 64'(0));
        enBase = enCnt10;
        applyStimulus(1'b1, 10'h155, 1'b0);
        tick();
        applyStimulus(1'b0, 10'h000, 1'b0);
        waitDone10(doneBase + 1, "reload");
        checkOutput("reload_value",     64'(doneLog10[doneBase]), 64'(10'h155));
        checkOutput("reload_en_pulses", 64'(enCnt10 - enBase), 64'(10));
        tick();

        // Valid pulsed with 10'h0AA during SHIFT is ignored
        $display("[TB] valid while busy");
        accBase  = acceptLog10.size();
        doneBase = doneLog10.size();
        applyStimulus(1'b1, 10'h1C3, 1'b0);
        tick();
        applyStimulus(1'b0, 10'h000, 1'b0);
        tick();
        tick();
        applyStimulus(1'b1, 10'h0AA, 1'b0);
        checkOutput("vbusy_ready", 64'(bus10.o_READY), 64'(0));
        tick();
        applyStimulus(1'b0, 10'h000, 1'b0);
        for (int i = 0; i < 20 && !bus10.o_DONE; i++) begin
            checkOutput("vbusy_ready_shift", 64'(bus10.o_READY), 64'(0));
            tick();
        end
        checkOutput("vbusy_done",       64'(bus10.o_DONE),  64'(1));
        checkOutput("vbusy_ready_done", 64'(bus10.o_READY), 64'(0));
        tick();
        checkOutput("vbusy_ready_back", 64'(bus10.o_READY), 64'(1));
        checkOutput("vbusy_accepts",    64'(acceptLog10.size() - accBase), 64'(1));
        checkOutput("vbusy_value",      64'(doneLog10[doneBase]), 64'(10'h1C3));

        // Width sweep with random words
        $display("[TB] width sweep");
        w2 = 2'($urandom_range(3, 0));
        loadW2(w2);
        loadW2(2'b10);
        w33 = {1'($urandom_range(1, 0)), 32'($urandom())};
        loadW33(w33);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

    // Global watchdog so the bench always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errorCount + 1, checkCount + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
